// File: rtl/fu_issue_sched_pkg.sv
// fu_issue_sched_pkg: shared types for the FU-class issue scheduler.
//   fu_state_t : per-FU occupancy state (IDLE -> BUSY -> DONE -> IDLE)
package fu_issue_sched_pkg;

    typedef enum logic [1:0] {
        FU_IDLE = 2'd0,
        FU_BUSY = 2'd1,
        FU_DONE = 2'd2
    } fu_state_t;

endpackage : fu_issue_sched_pkg

// File: rtl/fu_issue_sched_fu_slot.sv
// fu_slot: occupancy tracker for one functional-unit instance.
//   clock, reset (async, active-low), squash : clocking / flush
//   issue, issue_tag                         : grant and destination tag
//   wb_ack                                   : writeback accepted
//   req                                      : slot IDLE, can take an op
//   done, done_tag                           : result valid and its tag
// All outputs decode straight from the state/tag flops.
module fu_slot
    import fu_issue_sched_pkg::*;
#(
    parameter int unsigned LAT   = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             issue,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             wb_ack,
    output logic             req,
    output logic             done,
    output logic [TAG_W-1:0] done_tag
);

    localparam int unsigned CNT_W = $clog2(LAT + 1);

    fu_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [TAG_W-1:0]   tag_q,   tag_d;

    // State, counter and tag registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FU_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    // Next-state logic; squash overrides every other transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        unique case (state_q)
            FU_IDLE: begin
                if (issue) begin
                    tag_d = issue_tag;
                    if (LAT == 1) begin
                        state_d = FU_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = FU_BUSY;
                        cnt_d   = CNT_W'(LAT - 1);
                    end
                end
            end
            FU_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FU_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FU_DONE: begin
                if (wb_ack) begin
                    state_d = FU_IDLE;
                end
            end
            default: begin
                state_d = FU_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (squash) begin
            state_d = FU_IDLE;
            cnt_d   = '0;
        end
    end

    // Stale tags stay hidden outside DONE
    assign req      = (state_q == FU_IDLE);
    assign done     = (state_q == FU_DONE);
    assign done_tag = done ? tag_q : '0;

endmodule : fu_slot

// File: rtl/fu_issue_sched.sv
// fu_issue_sched: occupancy scheduler for one class of multi-cycle FUs.
//   clock, reset (async, active-low)  : clocking
//   squash                            : kill all BUSY/DONE FUs
//   fu_issue, issue_tag               : per-FU grants and destination tags
//   fu_wb_ack                         : per-FU writeback accept
//   fu_req, num_free                  : per-FU ready vector and its popcount
//   fu_done, done_tag                 : per-FU result valid and tag
// Optional macro FU_SCHED_STATS_EN adds stat_issues / stat_stall_cycles.
module fu_issue_sched
    import fu_issue_sched_pkg::*;
#(
    parameter int unsigned NUM_FU = 2,
    parameter int unsigned LAT    = 4,
    parameter int unsigned TAG_W  = 6
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             squash,
    input  logic [NUM_FU-1:0]                fu_issue,
    input  logic [NUM_FU-1:0][TAG_W-1:0]     issue_tag,
    input  logic [NUM_FU-1:0]                fu_wb_ack,
    output logic [NUM_FU-1:0]                fu_req,
    output logic [$clog2(NUM_FU+1)-1:0]      num_free,
    output logic [NUM_FU-1:0]                fu_done,
    output logic [NUM_FU-1:0][TAG_W-1:0]     done_tag
`ifdef FU_SCHED_STATS_EN
    ,
    output logic [31:0]                      stat_issues,
    output logic [31:0]                      stat_stall_cycles
`endif
);

    localparam int unsigned NF_W = $clog2(NUM_FU + 1);

    // One occupancy slot per FU instance
    for (genvar j = 0; j < NUM_FU; j++) begin : g_slot
        fu_slot #(
            .LAT   (LAT),
            .TAG_W (TAG_W)
        ) u_slot (
            .clock     (clock),
            .reset     (reset),
            .squash    (squash),
            .issue     (fu_issue[j]),
            .issue_tag (issue_tag[j]),
            .wb_ack    (fu_wb_ack[j]),
            .req       (fu_req[j]),
            .done      (fu_done[j]),
            .done_tag  (done_tag[j])
        );
    end

    // Free-FU count
    always_comb begin
        num_free = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            num_free = num_free + NF_W'(fu_req[j]);
        end
    end

`ifdef FU_SCHED_STATS_EN
    logic [NF_W-1:0] acc_cnt_c;
    logic            stall_c;

    // Accepted issues this cycle and writeback back-pressure
    always_comb begin
        acc_cnt_c = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            acc_cnt_c = acc_cnt_c + NF_W'(fu_issue[j] & fu_req[j] & ~squash);
        end
        stall_c = |(fu_done & ~fu_wb_ack);
    end

    // Free-running statistics, wrap modulo 2^32
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_issues       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            stat_issues <= stat_issues + 32'(acc_cnt_c);
            if (stall_c) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`else
    // Statistics counters not built
`endif

endmodule : fu_issue_sched

// File: tb/tb_fu_issue_sched.sv
// tb_fu_issue_sched: self-checking bench for fu_issue_sched.
// Main instance NUM_FU=2/LAT=4, second instance LAT=1.
module tb_fu_issue_sched;

    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT signals
    logic            squash = 1'b0;
    logic [1:0]      fu_issue = '0;
    logic [1:0][5:0] issue_tag = '0;
    logic [1:0]      fu_wb_ack = '0;
    logic [1:0]      fu_req;
    logic [1:0]      num_free;
    logic [1:0]      fu_done;
    logic [1:0][5:0] done_tag;

    // LAT=1 DUT signals
    logic            squash1 = 1'b0;
    logic [1:0]      fu_issue1 = '0;
    logic [1:0][5:0] issue_tag1 = '0;
    logic [1:0]      fu_wb_ack1 = '0;
    logic [1:0]      fu_req1;
    logic [1:0]      num_free1;
    logic [1:0]      fu_done1;
    logic [1:0][5:0] done_tag1;

`ifdef FU_SCHED_STATS_EN
    logic [31:0] stat_issues, stat_stall_cycles;
    logic [31:0] stat_issues1, stat_stall_cycles1;
`endif

    fu_issue_sched #(.NUM_FU(2), .LAT(LAT), .TAG_W(6)) u_dut (
        .clock     (clk),
        .reset     (rst_n),
        .squash    (squash),
        .fu_issue  (fu_issue),
        .issue_tag (issue_tag),
        .fu_wb_ack (fu_wb_ack),
        .fu_req    (fu_req),
        .num_free  (num_free),
        .fu_done   (fu_done),
        .done_tag  (done_tag)
`ifdef FU_SCHED_STATS_EN
        ,
        .stat_issues       (stat_issues),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    fu_issue_sched #(.NUM_FU(2), .LAT(1), .TAG_W(6)) u_dut1 (
        .clock     (clk),
        .reset     (rst_n),
        .squash    (squash1),
        .fu_issue  (fu_issue1),
        .issue_tag (issue_tag1),
        .fu_wb_ack (fu_wb_ack1),
        .fu_req    (fu_req1),
        .num_free  (num_free1),
        .fu_done   (fu_done1),
        .done_tag  (done_tag1)
`ifdef FU_SCHED_STATS_EN
        ,
        .stat_issues       (stat_issues1),
        .stat_stall_cycles (stat_stall_cycles1)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       sq;
        logic [1:0] iss;
        logic [5:0] t0;
        logic [5:0] t1;
        logic [1:0] ack;
        int         reps;
        logic [1:0] er;
        logic [1:0] enf;
        logic [1:0] ed;
        logic [5:0] edt0;
        logic [5:0] edt1;
    } vec_t;

    function automatic vec_t mk(input logic sq, input logic [1:0] iss,
                                input logic [5:0] t0, input logic [5:0] t1,
                                input logic [1:0] ack, input int reps,
                                input logic [1:0] er, input logic [1:0] enf,
                                input logic [1:0] ed, input logic [5:0] edt0,
                                input logic [5:0] edt1);
        vec_t v;
        v.sq = sq; v.iss = iss; v.t0 = t0; v.t1 = t1; v.ack = ack; v.reps = reps;
        v.er = er; v.enf = enf; v.ed = ed; v.edt0 = edt0; v.edt1 = edt1;
        return v;
    endfunction

    localparam int NV = 24;
    vec_t vt[NV];

    typedef struct {
        int         fu;
        logic [5:0] tag;
    } sb_t;
    sb_t sbq[$];

    // Expected statistics accumulated from the stimulus
    longint acc_iss   = 0;
    longint acc_stall = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Rows: inputs applied this cycle, outputs expected this cycle
        vt[0]  = mk(0, 2'b01,  5,  0, 2'b00,  1, 2'b11, 2, 2'b00, 0, 0);
        vt[1]  = mk(0, 2'b00,  0,  0, 2'b00,  3, 2'b10, 1, 2'b00, 0, 0);
        vt[2]  = mk(0, 2'b00,  0,  0, 2'b01,  1, 2'b10, 1, 2'b01, 5, 0);
        vt[3]  = mk(0, 2'b00,  0,  0, 2'b00,  1, 2'b11, 2, 2'b00, 0, 0);
        vt[4]  = mk(0, 2'b11,  3,  7, 2'b00,  1, 2'b11, 2, 2'b00, 0, 0);
        vt[5]  = mk(0, 2'b00,  0,  0, 2'b00,  3, 2'b00, 0, 2'b00, 0, 0);
        vt[6]  = mk(0, 2'b00,  0,  0, 2'b00, 17, 2'b00, 0, 2'b11, 3, 7);
        vt[7]  = mk(0, 2'b00,  0,  0, 2'b10,  1, 2'b00, 0, 2'b11, 3, 7);
        vt[8]  = mk(0, 2'b00,  0,  0, 2'b00,  2, 2'b10, 1, 2'b01, 3, 0);
        vt[9]  = mk(0, 2'b00,  0,  0, 2'b01,  1, 2'b10, 1, 2'b01, 3, 0);
        vt[10] = mk(0, 2'b00,  0,  0, 2'b00,  1, 2'b11, 2, 2'b00, 0, 0);
        vt[11] = mk(0, 2'b01,  9,  0, 2'b00,  1, 2'b11, 2, 2'b00, 0, 0);
        vt[12] = mk(0, 2'b00,  0,  0, 2'b00,  1, 2'b10, 1, 2'b00, 0, 0);
        vt[13] = mk(1, 2'b10,  0, 12, 2'b00,  1, 2'b10, 1, 2'b00, 0, 0);
        vt[14] = mk(0, 2'b00,  0,  0, 2'b00,  6, 2'b11, 2, 2'b00, 0, 0);
        vt[15] = mk(0, 2'b01,  4,  0, 2'b00,  1, 2'b11, 2, 2'b00, 0, 0);
        vt[16] = mk(0, 2'b01, 20,  0, 2'b01,  1, 2'b10, 1, 2'b00, 0, 0);
        vt[17] = mk(0, 2'b00,  0,  0, 2'b00,  2, 2'b10, 1, 2'b00, 0, 0);
        vt[18] = mk(0, 2'b00,  0,  0, 2'b01,  1, 2'b10, 1, 2'b01, 4, 0);
        vt[19] = mk(0, 2'b00,  0,  0, 2'b00,  1, 2'b11, 2, 2'b00, 0, 0);
        vt[20] = mk(0, 2'b01,  6,  0, 2'b00,  1, 2'b11, 2, 2'b00, 0, 0);
        vt[21] = mk(0, 2'b00,  0,  0, 2'b00,  3, 2'b10, 1, 2'b00, 0, 0);
        vt[22] = mk(1, 2'b00,  0,  0, 2'b00,  1, 2'b10, 1, 2'b01, 6, 0);
        vt[23] = mk(0, 2'b00,  0,  0, 2'b00,  1, 2'b11, 2, 2'b00, 0, 0);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst fu_req", 32'(fu_req), 32'h3);
        chk("rst num_free", 32'(num_free), 32'd2);
        chk("rst fu_done", 32'(fu_done), 32'h0);
        chk("rst done_tag", 32'(done_tag), 32'h0);
        chk("rst lat1 fu_req", 32'(fu_req1), 32'h3);
`ifdef FU_SCHED_STATS_EN
        chk("rst stat_issues", stat_issues, 32'd0);
        chk("rst stat_stall", stat_stall_cycles, 32'd0);
`endif
        rst_n = 1'b1;

        // LAT=1 instance: one-cycle latency and issue to a DONE FU
        @(negedge clk);
        fu_issue1 = 2'b01; issue_tag1[0] = 6'd11;
        @(negedge clk);
        chk("lat1 done c1", 32'(fu_done1), 32'h1);
        chk("lat1 tag c1", 32'(done_tag1[0]), 32'd11);
        chk("lat1 req c1", 32'(fu_req1), 32'h2);
        chk("lat1 nfree c1", 32'(num_free1), 32'd1);
        fu_issue1 = 2'b11; issue_tag1[0] = 6'd22; issue_tag1[1] = 6'd33;
        @(negedge clk);
        chk("lat1 done c2", 32'(fu_done1), 32'h3);
        chk("lat1 tag0 kept", 32'(done_tag1[0]), 32'd11);
        chk("lat1 tag1", 32'(done_tag1[1]), 32'd33);
        fu_issue1 = 2'b00; fu_wb_ack1 = 2'b01;
        @(negedge clk);
        chk("lat1 req after ack0", 32'(fu_req1), 32'h1);
        chk("lat1 done after ack0", 32'(fu_done1), 32'h2);
        fu_wb_ack1 = 2'b10;
        @(negedge clk);
        chk("lat1 req idle", 32'(fu_req1), 32'h3);
        chk("lat1 done idle", 32'(fu_done1), 32'h0);
        fu_wb_ack1 = 2'b00;

        // Table-driven directed vectors on the main instance
        for (int i = 0; i < NV; i++) begin
            for (int r = 0; r < vt[i].reps; r++) begin
                @(negedge clk);
                chk($sformatf("row%0d.%0d fu_req", i, r), 32'(fu_req), 32'(vt[i].er));
                chk($sformatf("row%0d.%0d num_free", i, r), 32'(num_free), 32'(vt[i].enf));
                chk($sformatf("row%0d.%0d fu_done", i, r), 32'(fu_done), 32'(vt[i].ed));
                chk($sformatf("row%0d.%0d done_tag0", i, r), 32'(done_tag[0]), 32'(vt[i].edt0));
                chk($sformatf("row%0d.%0d done_tag1", i, r), 32'(done_tag[1]), 32'(vt[i].edt1));
                squash       = vt[i].sq;
                fu_issue     = vt[i].iss;
                issue_tag[0] = vt[i].t0;
                issue_tag[1] = vt[i].t1;
                fu_wb_ack    = vt[i].ack;
                if (!vt[i].sq) begin
                    acc_iss += longint'(vt[i].iss[0] & vt[i].er[0]) + longint'(vt[i].iss[1] & vt[i].er[1]);
                end
                if (|(vt[i].ed & ~vt[i].ack)) acc_stall++;
            end
        end
        @(negedge clk);
        squash = 1'b0; fu_issue = '0; fu_wb_ack = '0;

        // Scoreboarded pseudo-random issue/ack stream
        begin
            bit         idle_b[2];
            int         due_b[2];
            logic [5:0] held_tag[2];
            int         nidle;
            bit         ed;
            bit         any_stall;
            for (int j = 0; j < 2; j++) begin
                idle_b[j] = 1'b1; due_b[j] = -1; held_tag[j] = '0;
            end
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                nidle = 0;
                any_stall = 1'b0;
                fu_issue = '0; fu_wb_ack = '0;
                for (int j = 0; j < 2; j++) begin
                    ed = (due_b[j] >= 0) && (c >= due_b[j]);
                    chk($sformatf("sb c%0d fu%0d req", c, j), 32'(fu_req[j]), 32'(idle_b[j]));
                    chk($sformatf("sb c%0d fu%0d done", c, j), 32'(fu_done[j]), 32'(ed));
                    if (idle_b[j]) nidle++;
                    if (ed && c == due_b[j]) begin
                        int k;
                        k = -1;
                        for (int q = 0; q < sbq.size(); q++) if (sbq[q].fu == j && k < 0) k = q;
                        if (k < 0) begin
                            n_checks++; n_errors++;
                            $display("FAIL sb c%0d fu%0d: no queued op, got done", c, j);
                        end else begin
                            held_tag[j] = sbq[k].tag;
                            sbq.delete(k);
                        end
                    end
                    if (ed) begin
                        chk($sformatf("sb c%0d fu%0d tag", c, j), 32'(done_tag[j]), 32'(held_tag[j]));
                    end
                    if (idle_b[j] && c < 360 && ($urandom % 3) == 0) begin
                        sb_t e;
                        fu_issue[j]  = 1'b1;
                        issue_tag[j] = 6'($urandom);
                        e.fu = j; e.tag = issue_tag[j];
                        sbq.push_back(e);
                        due_b[j]  = c + int'(LAT);
                        idle_b[j] = 1'b0;
                        acc_iss++;
                    end else if (ed && (c >= 380 || ($urandom % 2) == 0)) begin
                        fu_wb_ack[j] = 1'b1;
                        idle_b[j]    = 1'b1;
                        due_b[j]     = -1;
                    end else if (ed) begin
                        any_stall = 1'b1;
                    end
                end
                if (any_stall) acc_stall++;
                chk($sformatf("sb c%0d num_free", c), 32'(num_free), 32'(nidle));
            end
            @(negedge clk);
            fu_issue = '0; fu_wb_ack = '0;
            chk("sb queue drained", 32'(sbq.size()), 32'd0);
            chk("sb all idle", 32'(fu_req), 32'h3);
        end

`ifdef FU_SCHED_STATS_EN
        chk("stat_issues", stat_issues, 32'(acc_iss));
        chk("stat_stall_cycles", stat_stall_cycles, 32'(acc_stall));
`endif

        // Asynchronous reset while an op is in flight
        fu_issue = 2'b11; issue_tag[0] = 6'd1; issue_tag[1] = 6'd2;
        @(negedge clk);
        fu_issue = '0;
        chk("pre-rst fu_req", 32'(fu_req), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst fu_req", 32'(fu_req), 32'h3);
        chk("midrst num_free", 32'(num_free), 32'd2);
        chk("midrst fu_done", 32'(fu_done), 32'h0);
`ifdef FU_SCHED_STATS_EN
        chk("midrst stat_issues", stat_issues, 32'd0);
`endif
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fu_issue_sched

// File: doc/fu_issue_sched.md
Name: fu_issue_sched

Overview:
- Per-FU-class occupancy scheduler sitting between the RS issue-selection logic and one class of multi-cycle functional units (e.g. MULT).
- Tracks NUM_FU FU instances through IDLE/BUSY/DONE, drives the per-FU ready vector that feeds the selection logic's FU request input, and consumes its per-FU grants.
- Latches a destination tag per issue, counts down the fixed latency, and holds the result-valid until writeback acknowledge.
- Kills all in-flight work on squash.

Parameters:
- NUM_FU, 2, FU instances of this class (>=1)
- LAT, 4, issue-to-done latency in cycles (>=1)
- TAG_W, 6, destination physical-register tag width

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- squash  input  1  mispredict flush; kills every BUSY and DONE FU
- fu_issue  input  NUM_FU  per-FU issue grant from selection logic (FU j receives an op this cycle)
- issue_tag  input  NUM_FU x TAG_W  dest tag for FU j, valid when fu_issue[j]
- fu_wb_ack  input  NUM_FU  writeback accepted for FU j (meaningful only while fu_done[j])
- fu_req  output  NUM_FU  FU j IDLE and able to accept an op this cycle
- num_free  output  $clog2(NUM_FU+1)  popcount of fu_req
- fu_done  output  NUM_FU  FU j result valid
- done_tag  output  NUM_FU x TAG_W  tag latched at issue for FU j

Behaviour:
- Per-FU state: IDLE, BUSY, DONE. Per-FU down-counter cnt, width $clog2(LAT+1). Per-FU tag register.
- Reset (reset==0, asynchronous):
  - all FUs IDLE, cnt=0, tags=0
  - fu_req = all ones, num_free = NUM_FU, fu_done = 0, done_tag = 0
- fu_req, fu_done, done_tag and num_free are decoded purely from registered state. There is no combinational path from any input to any output.
- IDLE:
  - fu_issue[j] -> latch issue_tag[j].
  - LAT==1: next state DONE.
  - Otherwise: next state BUSY with cnt = LAT-1.
- BUSY: cnt decrements each cycle. cnt==1 -> DONE next cycle. An op issued at cycle t asserts fu_done from cycle t+LAT.
- DONE:
  - fu_done[j]=1, done_tag[j] valid.
  - Held indefinitely until fu_wb_ack[j], then IDLE next cycle. fu_req reasserts the following cycle, with no same-cycle reuse.
- fu_issue[j] while FU j is not IDLE (protocol violation): ignored; state and tag unchanged.
- fu_wb_ack[j] while not DONE: ignored.
- Issue to multiple FUs in one cycle is legal; each FU is handled independently.
- squash: every FU goes to IDLE next cycle, cnt=0. squash dominates any same-cycle fu_issue or fu_wb_ack. Tags need not be cleared but must not be visible, since fu_done=0.
- num_free is the exact popcount of fu_req. Width is sufficient for NUM_FU, with no saturation needed.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro: FU_SCHED_STATS_EN.
- Enabled:
  - Adds output stat_issues [31:0], counting accepted issues (fu_issue on IDLE FU, no squash).
  - Adds output stat_stall_cycles [31:0], counting cycles with any FU in DONE and its ack low.
  - Both counters are cleared by reset and wrap modulo 2^32.
- Disabled: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package: fu_state_t enum (FU_IDLE, FU_BUSY, FU_DONE).
- Single-FU slot (state + cnt + tag register) as sub-module fu_slot, generated NUM_FU times.
- Top level adds the popcount and the stats counters.

Test Plan:
- Reset, NUM_FU=2, LAT=4 -> fu_req=2'b11, num_free=2, fu_done=0.
- Issue fu_issue=2'b01, tag=5 at cycle 0 -> fu_req=2'b10 from cycle 1; fu_done=2'b01, done_tag[0]=5 at cycle 4; ack at 4 -> fu_req=2'b11 at cycle 5.
- Both FUs issued cycle 0 (tags 3,7), no ack -> fu_done=2'b11 held through cycle 20, num_free=0; ack FU1 only -> FU1 IDLE next cycle, FU0 stays DONE.
- Squash at cycle 2 after issue to FU0, with simultaneous fu_issue[1] -> cycle 3: fu_req=2'b11, fu_done=0, FU1 not occupied; no later fu_done.
- LAT=1 build: issue at cycle 0 -> fu_done at cycle 1; fu_issue to a DONE FU -> ignored, tag unchanged.
- FU_SCHED_STATS_EN: 3 accepted issues, 1 violating issue, 4 unacked DONE cycles -> stat_issues=3, stat_stall_cycles=4.
